// File: rtl/vnlp_norm_sqrt.sv
// Integer square root of the VNLP sum-of-squares, one result bit per cycle
// (restoring algorithm), with the element count carried alongside the result.
module vnlp_norm_sqrt #(
    parameter int W_IN   = 47,
    parameter int W_ROOT = 24,
    parameter int W_LEN  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                START,
    input  logic [W_IN-1:0]     NORM2,
    input  logic [W_LEN-1:0]    LEN,
    output logic                BUSY,
    output logic                DONE,
    output logic [W_ROOT-1:0]   NORM,
    output logic [W_ROOT:0]     REM,
    output logic [W_LEN-1:0]    LEN_OUT,
    output logic                ZERO_LEN
);

    localparam int W_RAD = 2 * W_ROOT;
    localparam int W_STP = W_ROOT + 2;
    localparam int W_RMO = W_ROOT + 1;
    localparam int W_CNT = $clog2(W_ROOT + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state;
    logic [W_RAD-1:0]   rad;
    logic [W_ROOT-1:0]  root;
    logic [W_ROOT-1:0]  rem_r;
    logic [W_LEN-1:0]   len_hold;
    logic [W_CNT-1:0]   cnt;

    logic [W_STP-1:0]   rem_sh;
    logic [W_STP-1:0]   trial;
    logic               ge;
    logic [W_RMO-1:0]   rem_nx;
    logic [W_ROOT-1:0]  root_nx;

    // Before the last step the partial remainder is at most 2*root of a
    // (W_ROOT-1)-bit root, so W_ROOT bits of stored remainder suffice; only
    // the final remainder needs the extra bit and goes straight to REM.
    always_comb begin
        rem_sh  = {rem_r, rad[W_RAD-1 -: 2]};
        trial   = {root, 2'b01};
        ge      = (rem_sh >= trial);
        rem_nx  = W_RMO'(ge ? rem_sh - trial : rem_sh);
        root_nx = {root[W_ROOT-2:0], ge};
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rad      <= '0;
            root     <= '0;
            rem_r    <= '0;
            len_hold <= '0;
            cnt      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            NORM     <= '0;
            REM      <= '0;
            LEN_OUT  <= '0;
            ZERO_LEN <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        rad      <= W_RAD'(NORM2);
                        root     <= '0;
                        rem_r    <= '0;
                        len_hold <= LEN;
                        cnt      <= W_CNT'(W_ROOT - 1);
                        BUSY     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rad   <= rad << 2;
                    root  <= root_nx;
                    rem_r <= rem_nx[W_ROOT-1:0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        NORM     <= root_nx;
                        REM      <= rem_nx;
                        LEN_OUT  <= len_hold;
                        ZERO_LEN <= (len_hold == '0);
                        DONE     <= 1'b1;
                        BUSY     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vnlp_norm_sqrt.md
# vnlp_norm_sqrt

Downstream stage of the VNLP linked-list norm engine. It captures the 47-bit sum-of-squares `NORM2` and the element count `LEN` when VNLP signals `DONE`, then computes the integer square root with a one-bit-per-cycle restoring algorithm. It presents the Euclidean norm `NORM`, the remainder `REM` and the latched length, with its own single-cycle `DONE` pulse to whatever consumes the result.

## Interface
- `W_IN`, 47: operand width; must match VNLP `NORM2` width and be odd or even, padded internally to `2*W_ROOT` bits.
- `W_ROOT`, 24: root width; equals ceil(`W_IN`/2).
- `W_LEN`, 7: length width; matches VNLP `LEN`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `START`  input  1  operand-valid strobe, driven by VNLP `DONE`; sampled only in IDLE.
- `NORM2`  input  `W_IN`  sum of squares; sampled on the accepted `START` edge.
- `LEN`  input  `W_LEN`  element count; sampled on the accepted `START` edge.
- `BUSY`  output  1  high while in CALC.
- `DONE`  output  1  one-cycle pulse; result valid.
- `NORM`  output  `W_ROOT`  floor(sqrt(`NORM2`)).
- `REM`  output  `W_ROOT`+1  `NORM2` − `NORM`².
- `LEN_OUT`  output  `W_LEN`  `LEN` captured with the operand.
- `ZERO_LEN`  output  1  `LEN_OUT` == 0.

## Operation
- States: IDLE, CALC.
- IDLE with `START`=1:
  - Load the radicand register with `NORM2`, zero-extended to 48 bits.
  - Clear the partial-root and partial-remainder registers.
  - Latch `LEN` into a holding register.
  - Set the iteration counter to `W_ROOT`−1.
  - Go to CALC.
- CALC, each cycle (restoring step):
  - Shift the top 2 radicand bits into the remainder: rem' = (rem<<2) | pair.
  - Trial value t = (root<<2) | 1.
  - If rem' ≥ t: rem ← rem' − t, root ← (root<<1)|1.
  - Else: rem ← rem', root ← root<<1.
  - Shift the radicand left by 2.
  - Decrement the counter.
- Widths:
  - Remainder datapath is `W_ROOT`+2 bits to hold the comparison.
  - Final `REM` fits in `W_ROOT`+1 bits, since `REM` ≤ 2·`NORM`.
  - No overflow is possible; no saturation logic.
- CALC with counter == 0:
  - Final step completes.
  - `NORM`, `REM`, `LEN_OUT` and `ZERO_LEN` are updated from the internal registers.
  - `DONE` is set to 1 for one cycle.
  - Return to IDLE.
- Output holding:
  - Outputs hold their last result until the next operation's `DONE`.
  - They do not change at `START` or during CALC.
- `START` in CALC is ignored; there is no queueing and the operand is lost. VNLP guarantees one `DONE` per run, so this is an error case only.
- `LEN`=0 is processed normally with constant latency. `ZERO_LEN` flags it, and `NORM2` is passed through unchecked.

## Timing
- Reset values: state IDLE; `BUSY`=0, `DONE`=0, `NORM`=0, `REM`=0, `LEN_OUT`=0, `ZERO_LEN`=1.
- `rst` has priority over `START` on the same edge.
- `rst` during CALC aborts the computation:
  - No `DONE` is issued.
  - Outputs are forced to their reset values on that edge.
- Latency:
  - Edge E0 samples `START`.
  - Iterations occur on edges E1…E`W_ROOT`.
  - `DONE`=1 and the new outputs appear after edge E`W_ROOT` (24 cycles).
  - `DONE` returns to 0 after E`W_ROOT`+1.
- `BUSY` is 1 from after E0 through after E`W_ROOT`−1, and 0 in the `DONE` cycle.
- Back-to-back: a `START` coincident with `DONE` is accepted, since the state is IDLE in that cycle. Throughput is one result per `W_ROOT`+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Small values, each `START` pulse one cycle:
  - `NORM2`=0, `LEN`=0 → after 24 cycles `DONE`=1, `NORM`=0, `REM`=0, `ZERO_LEN`=1.
  - `NORM2`=144, `LEN`=3 → `NORM`=12, `REM`=0, `LEN_OUT`=3, `ZERO_LEN`=0.
  - `NORM2`=150 → `NORM`=12, `REM`=6.
  - `NORM2`=1 → `NORM`=1, `REM`=0.
- Maximum operand: `NORM2`=2^47−1 (140737488355327), `LEN`=127 → `NORM`=11863283, `REM`=4817238, `LEN_OUT`=127.
- Latency and handshake:
  - `BUSY` is high exactly 24 cycles.
  - `DONE` is high exactly 1 cycle, 24 edges after `START`.
  - Outputs are stable between `DONE` pulses.
- `START` re-pulsed with `NORM2`=9 at cycle 5 of an operation on `NORM2`=150 → ignored; result is `NORM`=12, `REM`=6 at the original time.
- Back-to-back: second `START` (`NORM2`=10000) in the `DONE` cycle → second `DONE` 24 cycles later with `NORM`=100, `REM`=0.
- Reset:
  - `rst` at cycle 10 of CALC → no `DONE`, all outputs at reset values.
  - A following `START` with `NORM2`=49 yields `NORM`=7, `REM`=0.
  - `rst`=1 and `START`=1 on the same edge → stays IDLE.
